nibble_serial_adder: RTL and testbench

Multi-nibble serial adder controller that reuses the team's 4-bit ripple-carry adder (`four_bit_adder`) to add two wide operands one nibble per clock. It sits directly upstream and downstream of that adder: it slices latched operands into nibbles and drives the adder's `a`, `b` and `cin` inputs. It captures the adder's `s` and `cout` into a result register and returns the full-width sum over a valid/ready handshake.

---
 rtl/nibble_serial_adder.sv | 105 ++++++++++
 tb/tb_nibble_serial_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two 4*NIBBLES-bit operands one nibble per clock through an external 4-bit adder.
// Optional macro NIBBLE_SERIAL_SUBTRACT_EN adds an op_sub input for A-B.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_cin,
`ifdef NIBBLE_SERIAL_SUBTRACT_EN
  input  logic                 op_sub,
`endif
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [NIBBLES-1:0][3:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic accept, run, last, sub, cin_init;
  assign accept = state_q == IDLE && in_valid;
  assign run    = state_q == RUN;
  assign last   = idx_q == IW'(NIBBLES - 1);
`ifdef NIBBLE_SERIAL_SUBTRACT_EN
  logic sub_q;
  // Subtraction is A + ~B + 1, so the initial carry is forced high.
  always_ff @(posedge clk or posedge rst)
    if (rst) sub_q <= 1'b0;
    else if (accept) sub_q <= op_sub;
  assign sub      = sub_q;
  assign cin_init = op_sub | op_cin;
`else
  assign sub      = 1'b0;
  assign cin_init = op_cin;
`endif
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (accept) begin
      a_d     = op_a;
      b_d     = op_b;
      acc_d   = '0;
      idx_d   = '0;
      carry_d = cin_init;
      state_d = RUN;
    end
    if (run) begin
      acc_d[idx_q] = add_s;
      carry_d      = add_cout;
      idx_d        = last ? idx_q : idx_q + IW'(1);
      state_d      = last ? DONE : RUN;
    end
    // Result registers load only on completion so sum/cout stay put outside DONE.
    if (run && last) begin
      res_d  = acc_d;
      cout_d = add_cout;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign add_a     = run ? a_q[idx_q] : 4'h0;
  assign add_b     = run ? b_q[idx_q] ^ {4{sub}} : 4'h0;
  assign add_cin   = run & carry_q;
  assign sum       = res_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: scoreboard bench for the 4-nibble and 1-nibble configurations with a behavioural 4-bit adder.
module tb_nibble_serial_adder;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        iv4 = 1'b0, ir4, cin4 = 1'b0, sub4 = 1'b0, ac4, c4, ov4, ordy4 = 1'b1, co4;
  logic [15:0] a4 = '0, b4 = '0, sum4;
  logic [3:0]  aa4, ab4, s4;
  logic        iv1 = 1'b0, ir1, cin1 = 1'b0, sub1 = 1'b0, ac1, c1, ov1, ordy1 = 1'b1, co1;
  logic [3:0]  a1 = '0, b1 = '0, sum1, aa1, ab1, s1;
  assign {c4, s4} = 5'(aa4) + 5'(ab4) + 5'(ac4);
  assign {c1, s1} = 5'(aa1) + 5'(ab1) + 5'(ac1);
  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op_a(a4), .op_b(b4), .op_cin(cin4),
`ifdef NIBBLE_SERIAL_SUBTRACT_EN
    .op_sub(sub4),
`endif
    .add_a(aa4), .add_b(ab4), .add_cin(ac4), .add_s(s4), .add_cout(c4),
    .out_valid(ov4), .out_ready(ordy4), .sum(sum4), .cout(co4)
  );
  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op_a(a1), .op_b(b1), .op_cin(cin1),
`ifdef NIBBLE_SERIAL_SUBTRACT_EN
    .op_sub(sub1),
`endif
    .add_a(aa1), .add_b(ab1), .add_cin(ac1), .add_s(s1), .add_cout(c1),
    .out_valid(ov1), .out_ready(ordy1), .sum(sum1), .cout(co1)
  );
  typedef struct {logic [15:0] a, b; logic cin, sub; logic [15:0] es; logic ec;} vec_t;
  typedef struct {logic [15:0] s; logic c;} exp_t;
  exp_t q[$];
  vec_t vt[$];
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    logic [16:0] r;
    r = sub ? 17'(a) + 17'(~b) + 17'd1 : 17'(a) + 17'(b) + 17'(cin);
    return '{a, b, cin, sub, r[15:0], r[16]};
  endfunction
  always @(negedge clk)
    if (!rst && ov4 && ordy4) begin
      exp_t e;
      if (q.size() == 0) chk("sb_unexpected", 32'(q.size()), 1);
      else begin
        e = q.pop_front();
        chk("sum4", 32'(sum4), 32'(e.s));
        chk("cout4", 32'(co4), 32'(e.c));
      end
    end
  task automatic accept4(input vec_t v);
    int n = 0;
    while (!ir4 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept4_ready", 32'(ir4), 1);
    a4 = v.a; b4 = v.b; cin4 = v.cin; sub4 = v.sub; iv4 = 1'b1;
    q.push_back('{v.es, v.ec});
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask
  task automatic wait_done4(output int cyc, output logic busy);
    cyc = 0; busy = 1'b0;
    while (!ov4 && cyc < 20) begin
      if (ir4) busy = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
  endtask
  task automatic run4(input vec_t v);
    int cyc;
    logic busy;
    accept4(v);
    wait_done4(cyc, busy);
    chk("latency4", 32'(cyc), 4);
    chk("in_ready_busy4", 32'(busy), 0);
    @(posedge clk); #1;
    chk("out_valid_drop4", 32'(ov4), 0);
    chk("in_ready_back4", 32'(ir4), 1);
  endtask
  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic [3:0] es, input logic ec);
    int n = 0;
    while (!ir1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    a1 = a; b1 = b; cin1 = cin; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    chk("n1_run_no_valid", 32'(ov1), 0);
    @(posedge clk); #1;
    chk("n1_valid", 32'(ov1), 1);
    chk("n1_sum", 32'(sum1), 32'(es));
    chk("n1_cout", 32'(co1), 32'(ec));
    @(posedge clk); #1;
    chk("n1_in_ready_back", 32'(ir1), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cyc;
    logic busy;
    vt.push_back('{16'h1234, 16'h0FCC, 1'b0, 1'b0, 16'h2200, 1'b0});
    vt.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
    vt.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0});
    vt.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
`ifdef NIBBLE_SERIAL_SUBTRACT_EN
    vt.push_back('{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1});
    vt.push_back('{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0});
    for (int i = 0; i < 4; i++) vt.push_back(mk(16'($urandom), 16'($urandom), 1'($urandom), 1'b1));
`endif
    for (int i = 0; i < 8; i++) vt.push_back(mk(16'($urandom), 16'($urandom), 1'($urandom), 1'b0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ir4), 1);
    chk("rst_out_valid", 32'(ov4), 0);
    chk("rst_sum", 32'(sum4), 0);
    chk("rst_cout", 32'(co4), 0);
    chk("rst_add_bus", 32'({aa4, ab4, ac4}), 0);
    @(negedge clk) rst = 1'b0;
    foreach (vt[i]) run4(vt[i]);
    ordy4 = 1'b0;
    accept4(mk(16'h1111, 16'h2222, 1'b0, 1'b0));
    a4 = 16'hAAAA; b4 = 16'h5555; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    wait_done4(cyc, busy);
    chk("bp_latency", 32'(cyc), 3);
    for (int i = 0; i < 5; i++) begin
      iv4 = (i == 1); a4 = 16'($urandom); b4 = 16'($urandom);
      @(posedge clk); #1;
      iv4 = 1'b0;
      chk("bp_hold_valid", 32'(ov4), 1);
      chk("bp_hold_sum", 32'(sum4), 32'h3333);
      chk("bp_hold_cout", 32'(co4), 0);
      chk("bp_in_ready_low", 32'(ir4), 0);
    end
    ordy4 = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_back", 32'(ir4), 1);
    chk("bp_out_valid_drop", 32'(ov4), 0);
    @(posedge clk); #1;
    chk("bp_no_ghost_op", 32'(ir4), 1);
    chk("bp_sb_empty", 32'(q.size()), 0);
    accept4(mk(16'h1234, 16'h1111, 1'b0, 1'b0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("run_nibble2", 32'(aa4), 2);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(ov4), 0);
    chk("arst_sum", 32'(sum4), 0);
    chk("arst_cout", 32'(co4), 0);
    chk("arst_in_ready", 32'(ir4), 1);
    chk("arst_add_bus", 32'({aa4, ab4, ac4}), 0);
    q.delete();
    @(negedge clk) rst = 1'b0;
    run4('{16'h0008, 16'h0003, 1'b0, 1'b0, 16'h000B, 1'b0});
    run1(4'd8, 4'd3, 1'b0, 4'hB, 1'b0);
    run1(4'd7, 4'd9, 1'b0, 4'h0, 1'b1);
    run1(4'd15, 4'd0, 1'b1, 4'h0, 1'b1);
    chk("sb_leftover", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
